// File: rtl/linear_input_loader_if.sv
// linear_input_loader_if
//   Word stream carrying weights, bias and feature rows into the loader.
//
//   Handshake: a word transfers on a rising clock edge where s_valid && s_ready.
//   The master holds s_data/s_last stable while s_valid=1 and s_ready=0.
//   s_ready does not depend on s_valid. s_last marks the final word of a frame.
//
//   Signals:
//     s_valid  master->slave  word valid
//     s_ready  slave->master  slave can accept a word
//     s_data   master->slave  PRECISION-wide word
//     s_last   master->slave  final word of a frame
interface linear_input_loader_if #(
  parameter int PRECISION = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [PRECISION-1:0] s_data;
  logic                 s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/linear_input_loader.sv
// linear_input_loader
//   Unpacks a word stream into the parallel weight vector, bias word and
//   feature matrix used by the linear-layer multiplier. A complete operand
//   set is published atomically, with a one-cycle out_valid strobe. When
//   keep_params is high at emit, the next frame carries features only, and
//   the previous weights and bias are reused.
//
//   Frame layout:
//     full frame:    N weights, BIAS_WORDS bias words (LS word first),
//                    NUM_FEATURES*N features (row-major)
//     feature-only:  NUM_FEATURES*N features
//
//   Ports:
//     clk, rst      clock; synchronous active-high reset
//     s             stream slave (s_valid/s_ready/s_data/s_last)
//     keep_params   sampled in the emit cycle only
//     weights_out   published weight vector
//     bias_out      published bias
//     features_out  published feature matrix
//     out_valid     one-cycle strobe: new operand set published
//     frame_err     one-cycle strobe: malformed frame discarded
//     state_dbg     current FSM state, for observation only
//
//   BIAS_PRECISION must be an integer multiple of PRECISION.
module linear_input_loader #(
  parameter int PRECISION      = 8,
  parameter int BIAS_PRECISION = 32,
  parameter int NUM_FEATURES   = 2,
  parameter int N              = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  linear_input_loader_if.slave                          s,
  input  logic                                          keep_params,
  output logic [N-1:0][PRECISION-1:0]                   weights_out,
  output logic [BIAS_PRECISION-1:0]                     bias_out,
  output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] features_out,
  output logic                                          out_valid,
  output logic                                          frame_err,
  output logic [2:0]                                    state_dbg
);

  localparam int BIAS_WORDS = BIAS_PRECISION / PRECISION;
  localparam int FEAT_WORDS = NUM_FEATURES * N;
  // The counter is wide enough for the longest segment.
  localparam int CW         = $clog2(N + BIAS_WORDS + FEAT_WORDS);

  typedef enum logic [2:0] {
    S_WEIGHTS = 3'd0,
    S_BIAS    = 3'd1,
    S_FEAT    = 3'd2,
    S_EMIT    = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t                                        state_q, state_d;
  logic [CW-1:0]                                 cnt_q, cnt_d;
  logic                                          err_d;
  logic                                          ready;
  logic                                          accept;
  logic                                          publish;

  // Working buffers. These fill during a frame and are copied out only at emit.
  logic [N-1:0][PRECISION-1:0]                   w_buf;
  logic [BIAS_WORDS-1:0][PRECISION-1:0]          b_buf;
  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] f_buf;
  logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0] f_merged;

  // Ready depends only on state, and is held low while in reset.
  assign ready     = !rst && (state_q != S_EMIT);
  assign s.s_ready = ready;
  assign accept    = s.s_valid && ready;
  assign out_valid = (state_q == S_EMIT);
  assign state_dbg = state_q;

  // The feature buffer, with the current word dropped into its slot. At emit,
  // this lets the final feature word reach the outputs on the same edge
  // that accepts it.
  always_comb begin
    f_merged = f_buf;
    for (int r = 0; r < NUM_FEATURES; r++) begin
      for (int c = 0; c < N; c++) begin
        if (cnt_q == CW'(r * N + c)) f_merged[r][c] = s.s_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    publish = 1'b0;
    case (state_q)
      S_WEIGHTS: begin
        if (accept) begin
          if (s.s_last) begin
            err_d   = 1'b1;
            state_d = S_WEIGHTS;
            cnt_d   = '0;
          end else if (cnt_q == CW'(N - 1)) begin
            state_d = S_BIAS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_BIAS: begin
        if (accept) begin
          if (s.s_last) begin
            err_d   = 1'b1;
            state_d = S_WEIGHTS;
            cnt_d   = '0;
          end else if (cnt_q == CW'(BIAS_WORDS - 1)) begin
            state_d = S_FEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FEAT: begin
        if (accept) begin
          if (cnt_q == CW'(FEAT_WORDS - 1)) begin
            cnt_d = '0;
            if (s.s_last) begin
              state_d = S_EMIT;
              publish = 1'b1;
            end else begin
              // The frame is overlong, so skip to its real end.
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (s.s_last) begin
            err_d   = 1'b1;
            state_d = S_WEIGHTS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_EMIT: begin
        cnt_d   = '0;
        state_d = keep_params ? S_FEAT : S_WEIGHTS;
      end
      S_DRAIN: begin
        if (accept && s.s_last) begin
          state_d = S_WEIGHTS;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_WEIGHTS;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WEIGHTS;
      cnt_q        <= '0;
      frame_err    <= 1'b0;
      w_buf        <= '0;
      b_buf        <= '0;
      f_buf        <= '0;
      weights_out  <= '0;
      bias_out     <= '0;
      features_out <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_err <= err_d;
      // A discarded frame leaves partial data in the buffers. The next
      // frame after any error is a full frame, which rewrites every slot
      // before the next publish.
      if (accept) begin
        case (state_q)
          S_WEIGHTS: begin
            for (int i = 0; i < N; i++) begin
              if (cnt_q == CW'(i)) w_buf[i] <= s.s_data;
            end
          end
          S_BIAS: begin
            for (int k = 0; k < BIAS_WORDS; k++) begin
              if (cnt_q == CW'(k)) b_buf[k] <= s.s_data;
            end
          end
          S_FEAT:  f_buf <= f_merged;
          default: ;
        endcase
      end
      if (publish) begin
        weights_out  <= w_buf;
        bias_out     <= b_buf;
        features_out <= f_merged;
      end
    end
  end

endmodule

// File: tb/tb_linear_input_loader.sv
// tb_linear_input_loader
//   Self-checking bench for linear_input_loader. It runs a table of directed
//   frames (normal, feature-only, early/missing s_last, gaps), then a
//   mid-frame reset, then randomized frames. A frame-level reference model
//   feeds the expected queue for every out_valid.
module tb_linear_input_loader;
  localparam int P        = 8;
  localparam int BP       = 32;
  localparam int NF       = 2;
  localparam int N        = 16;
  localparam int BW       = BP / P;
  localparam int FEAT_LEN = NF * N;
  localparam int FULL_LEN = N + BW + FEAT_LEN;
  localparam int W        = N * P + BP + NF * N * P;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic keep_params;
  logic [N-1:0][P-1:0]        weights_out;
  logic [BP-1:0]              bias_out;
  logic [NF-1:0][N-1:0][P-1:0] features_out;
  logic out_valid, frame_err;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  linear_input_loader_if #(.PRECISION(P)) sif ();

  linear_input_loader #(
    .PRECISION(P), .BIAS_PRECISION(BP), .NUM_FEATURES(NF), .N(N)
  ) dut (
    .clk(clk), .rst(rst), .s(sif), .keep_params(keep_params),
    .weights_out(weights_out), .bias_out(bias_out), .features_out(features_out),
    .out_valid(out_valid), .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int seen_emits = 0, seen_errs = 0;
  int exp_emits  = 0, exp_errs  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [N*P-1:0]    m_w;
  logic [BP-1:0]     m_b;
  logic [NF*N*P-1:0] m_f;
  logic [P-1:0]      m_cur[$];
  bit                m_full  = 1'b1;
  bit                m_drain = 1'b0;

  task automatic model_reset();
    m_w = '0; m_b = '0; m_f = '0;
    m_cur.delete();
    m_full = 1'b1; m_drain = 1'b0;
    exp_q.delete();
  endtask

  // Called once per accepted word. A frame is good when its s_last lands
  // exactly on the expected length; its operand set then goes on the queue.
  task automatic model_accept(input logic [P-1:0] d, input bit last, input bit keep,
                              output bit emitted);
    int len;
    int base;
    emitted = 1'b0;
    if (m_drain) begin
      if (last) m_drain = 1'b0;
      return;
    end
    m_cur.push_back(d);
    len = m_full ? FULL_LEN : FEAT_LEN;
    if (m_cur.size() == len) begin
      if (last) begin
        base = m_full ? N + BW : 0;
        if (m_full) begin
          for (int i = 0; i < N; i++)  m_w[i*P +: P] = m_cur[i];
          for (int k = 0; k < BW; k++) m_b[k*P +: P] = m_cur[N+k];
        end
        for (int j = 0; j < FEAT_LEN; j++) m_f[j*P +: P] = m_cur[base+j];
        exp_q.push_back({m_w, m_b, m_f});
        exp_emits++;
        emitted = 1'b1;
        m_full = !keep;
      end else begin
        exp_errs++;
        m_drain = 1'b1;
        m_full  = 1'b1;
      end
      m_cur.delete();
    end else if (last) begin
      exp_errs++;
      m_full = 1'b1;
      m_cur.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        seen_emits++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out_valid: got 1 expected 0");
        end else begin
          check("published_set", {weights_out, bias_out, features_out}, exp_q.pop_front());
        end
      end
      if (frame_err) seen_errs++;
    end
  end

  // ---------------- driver ----------------
  logic [P-1:0] fr_d[$];
  bit           fr_l[$];

  // kind 0: reference full frame; 1: feature-only 0x05; 2: s_last on weight 7;
  // 3: no s_last on feature 31 plus three drain words; 4: kind 0 with bit 7 flipped
  task automatic build_frame(input int kind);
    logic [P-1:0]  x;
    logic [BP-1:0] bias_c;
    fr_d.delete(); fr_l.delete();
    x = (kind == 4) ? 8'h80 : 8'h00;
    bias_c = 32'h12345678;
    if (kind == 1) begin
      for (int j = 0; j < FEAT_LEN; j++) begin fr_d.push_back(8'h05); fr_l.push_back(1'b0); end
    end else begin
      for (int i = 0; i < N; i++)  begin fr_d.push_back(P'(i + 1) ^ x); fr_l.push_back(1'b0); end
      for (int k = 0; k < BW; k++) begin fr_d.push_back(bias_c[k*P +: P] ^ x); fr_l.push_back(1'b0); end
      for (int j = 0; j < FEAT_LEN; j++) begin fr_d.push_back(P'(16 + j) ^ x); fr_l.push_back(1'b0); end
    end
    fr_l[fr_l.size()-1] = 1'b1;
    if (kind == 2) begin
      while (fr_d.size() > 8) begin void'(fr_d.pop_back()); void'(fr_l.pop_back()); end
      fr_l[7] = 1'b1;
    end
    if (kind == 3) begin
      fr_l[fr_l.size()-1] = 1'b0;
      for (int k = 0; k < 3; k++) begin fr_d.push_back(8'h99); fr_l.push_back(k == 2); end
    end
  endtask

  // Sends fr_d/fr_l with optional random idle gaps. keep_params is
  // randomized on every word but the last, and held at frame_keep from the
  // last word through two idle cycles. With tail=1, the emit strobe and
  // ready timing right after the last word are checked.
  task automatic send_frame(input bit frame_keep, input int gap_pct, input bit tail);
    bit emitted, e, done;
    int guard;
    emitted = 1'b0;
    for (int i = 0; i < fr_d.size(); i++) begin
      while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        @(negedge clk);
        sif.s_valid = 1'b0;
        keep_params = 1'($urandom_range(1, 0));
      end
      done  = 1'b0;
      guard = 0;
      while (!done) begin
        @(negedge clk);
        sif.s_valid = 1'b1;
        sif.s_data  = fr_d[i];
        sif.s_last  = fr_l[i];
        keep_params = (i == fr_d.size() - 1) ? frame_keep : 1'($urandom_range(1, 0));
        if (sif.s_ready) begin
          model_accept(fr_d[i], fr_l[i], frame_keep, e);
          if (e) emitted = 1'b1;
          done = 1'b1;
        end else if (++guard > 50) begin
          total++; bad++;
          $display("FAIL ready_timeout: got s_ready=0 for 50 cycles expected 1");
          sif.s_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    keep_params = frame_keep;
    if (tail) begin
      check("emit_strobe", W'(out_valid), W'(emitted));
      check("ready_in_emit", W'(sif.s_ready), W'(!emitted));
    end
    @(negedge clk);
    if (tail) begin
      check("strobe_one_cycle", W'(out_valid), W'(0));
      check("ready_after_emit", W'(sif.s_ready), W'(1));
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string        name;
    int           kind;
    bit           keep;
    int           gap;
    int           n_emit;
    int           n_err;
    logic [BP-1:0] bias;
    logic [P-1:0]  w3;
    logic [P-1:0]  f115;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int e0, r0, len, et, k, nd;
    bit fk;

    vecs[0] = '{"full_keep",      0, 1'b1, 0,  1, 0, 32'h12345678, 8'h04, 8'h2F};
    vecs[1] = '{"feat_only",      1, 1'b0, 0,  1, 0, 32'h12345678, 8'h04, 8'h05};
    vecs[2] = '{"early_last",     2, 1'b0, 0,  0, 1, 32'h12345678, 8'h04, 8'h05};
    vecs[3] = '{"full_after_err", 0, 1'b0, 0,  1, 0, 32'h12345678, 8'h04, 8'h2F};
    vecs[4] = '{"missing_last",   3, 1'b0, 0,  0, 1, 32'h12345678, 8'h04, 8'h2F};
    vecs[5] = '{"full_alt_gaps",  4, 1'b0, 50, 1, 0, 32'h92B4D6F8, 8'h84, 8'hAF};
    vecs[6] = '{"full_gaps",      0, 1'b0, 50, 1, 0, 32'h12345678, 8'h04, 8'h2F};

    // clock / reset
    rst = 1'b1; keep_params = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ready",   W'(sif.s_ready), W'(0));
    check("reset_outputs", {weights_out, bias_out, features_out}, W'(0));
    check("reset_valid",   W'(out_valid), W'(0));
    check("reset_err",     W'(frame_err), W'(0));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", W'(sif.s_ready), W'(1));

    // table-driven directed frames
    for (int r = 0; r < 7; r++) begin
      e0 = seen_emits; r0 = seen_errs;
      build_frame(vecs[r].kind);
      send_frame(vecs[r].keep, vecs[r].gap, 1'b1);
      check({vecs[r].name, "_emits"}, W'(seen_emits - e0), W'(vecs[r].n_emit));
      check({vecs[r].name, "_errs"},  W'(seen_errs - r0),  W'(vecs[r].n_err));
      check({vecs[r].name, "_bias"},  W'(bias_out), W'(vecs[r].bias));
      check({vecs[r].name, "_w3"},    W'(weights_out[3]), W'(vecs[r].w3));
      check({vecs[r].name, "_f1_15"}, W'(features_out[1][15]), W'(vecs[r].f115));
    end

    // reset after word 20 of a full frame
    build_frame(0);
    while (fr_d.size() > 20) begin void'(fr_d.pop_back()); void'(fr_l.pop_back()); end
    send_frame(1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready",   W'(sif.s_ready), W'(0));
    check("midrst_outputs", {weights_out, bias_out, features_out}, W'(0));
    check("midrst_valid",   W'(out_valid), W'(0));
    rst = 1'b0;
    model_reset();
    e0 = seen_emits;
    build_frame(0);
    send_frame(1'b0, 0, 1'b1);
    check("post_rst_emits", W'(seen_emits - e0), W'(1));
    check("post_rst_bias",  W'(bias_out), W'(32'h12345678));
    check("post_rst_w3",    W'(weights_out[3]), W'(8'h04));
    check("post_rst_f1_15", W'(features_out[1][15]), W'(8'h2F));

    // randomized frames, with occasional malformed ones
    for (int f = 0; f < 40; f++) begin
      len = m_full ? FULL_LEN : FEAT_LEN;
      fr_d.delete(); fr_l.delete();
      for (int i = 0; i < len; i++) begin
        fr_d.push_back(P'($urandom_range(255, 0)));
        fr_l.push_back(1'b0);
      end
      fr_l[len-1] = 1'b1;
      et = $urandom_range(9, 0);
      if (et == 0) begin
        k = $urandom_range(len - 2, 0);
        while (fr_d.size() > k + 1) begin void'(fr_d.pop_back()); void'(fr_l.pop_back()); end
        fr_l[k] = 1'b1;
      end else if (et == 1) begin
        fr_l[len-1] = 1'b0;
        nd = $urandom_range(3, 1);
        for (int i = 0; i < nd; i++) begin
          fr_d.push_back(P'($urandom_range(255, 0)));
          fr_l.push_back(i == nd - 1);
        end
      end
      fk = 1'($urandom_range(1, 0));
      send_frame(fk, $urandom_range(60, 0), 1'b1);
    end

    // final report
    repeat (3) @(negedge clk);
    check("total_emits",   W'(seen_emits), W'(exp_emits));
    check("total_errs",    W'(seen_errs), W'(exp_errs));
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
